// File: rtl/axis_pkg.sv
// axis_pkg: shared state encodings and saturating counter helper for AXI-Stream stages.
//   ST_PASS / ST_DROP : frame limiter states
//   sat_inc(v, w)     : v+1 clamped at 2^w-1 (w <= 32)
package axis_pkg;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        return ({1'b0, v} < lim) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/axis_frame_len_limiter_if.sv
// axis_frame_len_limiter_if: AXI-Stream bundle used on both sides of the frame length limiter.
//   tdata/tvalid/tlast/tuser : source -> sink
//   tready                   : sink -> source
//   master modport = source side, slave modport = sink side
interface axis_frame_len_limiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: two-entry register slice (main + skid) with registered ready and full throughput.
//   clk, rst            : clock, async active-high reset
//   in_data/in_valid    : upstream payload and valid; in_ready is registered
//   out_data/out_valid  : downstream payload and valid, one cycle after the input handshake
//   out_ready           : downstream ready
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, ready_q;
    logic             acc, load_main;

    assign acc       = in_valid && ready_q;
    assign load_main = !main_valid_q || out_ready;
    assign in_ready  = ready_q;
    assign out_data  = main_q;
    assign out_valid = main_valid_q;

    // ready_q tracks "skid empty", so a beat can only arrive while the skid has room.
    always_comb begin
        main_d       = load_main ? (skid_valid_q ? skid_q : in_data) : main_q;
        main_valid_d = load_main ? (skid_valid_q || acc) : 1'b1;
        skid_d       = (!load_main && acc) ? in_data : skid_q;
        skid_valid_d = load_main ? 1'b0 : (skid_valid_q || acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end
endmodule

// File: rtl/axis_frame_len_limiter.sv
// axis_frame_len_limiter: enforces MIN_LEN/MAX_LEN beats per frame, truncating and flagging bad frames.
//   clk, rst        : clock, async active-high reset
//   input_axis      : upstream AXI-Stream (slave)
//   output_axis     : downstream AXI-Stream (master); tuser marks a bad frame on its tlast beat
//   frame_len       : saturated input beat count of the last completed frame
//   frame_len_valid : one-cycle pulse when frame_len updates
//   frame_too_long  : pulse with frame_len_valid when the frame exceeded MAX_LEN
//   frame_too_short : pulse with frame_len_valid when the frame was shorter than MIN_LEN
module axis_frame_len_limiter
    import axis_pkg::*;
#(
    parameter int   DATA_WIDTH           = 8,
    parameter int   LEN_WIDTH            = 16,
    parameter int   MAX_LEN              = 16,
    parameter int   MIN_LEN              = 2,
    parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    axis_frame_len_limiter_if.slave  input_axis,
    axis_frame_len_limiter_if.master output_axis,
    output logic [LEN_WIDTH-1:0]    frame_len,
    output logic                    frame_len_valid,
    output logic                    frame_too_long,
    output logic                    frame_too_short
);
    if (MIN_LEN < 1 || MIN_LEN > MAX_LEN || LEN_WIDTH > 32 ||
        longint'(MAX_LEN) >= (longint'(1) << LEN_WIDTH)) begin : g_bad_params
        $error("axis_frame_len_limiter: illegal MIN_LEN/MAX_LEN/LEN_WIDTH combination");
    end

    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d, cnt_cur, len_q, len_d;
    logic                   bad_q, bad_d, bad_cur;
    logic                   len_valid_q, len_valid_d, too_long_q, too_long_d, too_short_q, too_short_d;
    logic                   acc, trunc, fwd_bad, skid_ready;
    logic [DATA_WIDTH+1:0]  out_word;

    assign acc      = input_axis.tvalid && input_axis.tready;
    // cnt_cur / bad_cur include the beat currently on the input.
    assign cnt_cur  = LEN_WIDTH'(sat_inc(32'(cnt_q), LEN_WIDTH));
    assign bad_cur  = bad_q || input_axis.tuser;
    // Reaching MAX_LEN without tlast ends the forwarded frame here; the rest is dropped.
    assign trunc    = !input_axis.tlast && cnt_cur == MAX_L;
    assign fwd_bad  = trunc || (input_axis.tlast && (bad_cur || cnt_cur < MIN_L));

    assign input_axis.tready = (state_q == ST_DROP) || skid_ready;

    axis_skid_reg #(.WIDTH(DATA_WIDTH + 2)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({input_axis.tdata, input_axis.tlast || trunc, fwd_bad ? USER_BAD_FRAME_VALUE : 1'b0}),
        .in_valid  (input_axis.tvalid && state_q == ST_PASS),
        .in_ready  (skid_ready),
        .out_data  (out_word),
        .out_valid (output_axis.tvalid),
        .out_ready (output_axis.tready)
    );

    assign output_axis.tdata = out_word[DATA_WIDTH+1:2];
    assign output_axis.tlast = out_word[1];
    assign output_axis.tuser = out_word[0];

    assign frame_len       = len_q;
    assign frame_len_valid = len_valid_q;
    assign frame_too_long  = too_long_q;
    assign frame_too_short = too_short_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        len_d       = len_q;
        len_valid_d = 1'b0;
        too_long_d  = 1'b0;
        too_short_d = 1'b0;
        if (acc && input_axis.tlast) begin
            state_d     = ST_PASS;
            cnt_d       = '0;
            bad_d       = 1'b0;
            len_d       = cnt_cur;
            len_valid_d = 1'b1;
            too_long_d  = state_q == ST_DROP;
            too_short_d = state_q == ST_PASS && cnt_cur < MIN_L;
        end else if (acc) begin
            cnt_d   = cnt_cur;
            bad_d   = bad_cur;
            state_d = (state_q == ST_PASS && trunc) ? ST_DROP : state_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PASS;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            len_q       <= '0;
            len_valid_q <= 1'b0;
            too_long_q  <= 1'b0;
            too_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            len_q       <= len_d;
            len_valid_q <= len_valid_d;
            too_long_q  <= too_long_d;
            too_short_q <= too_short_d;
        end
    end
endmodule

// File: tb/tb_axis_frame_len_limiter.sv
// tb_axis_frame_len_limiter: directed self-checking bench for axis_frame_len_limiter (MAX_LEN=4, MIN_LEN=2).
module tb_axis_frame_len_limiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_len;
    logic        frame_len_valid, frame_too_long, frame_too_short;
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  obq[$];
    logic [17:0] stq[$];

    always #5 clk = ~clk;

    axis_frame_len_limiter_if #(.DATA_WIDTH(8)) in_if ();
    axis_frame_len_limiter_if #(.DATA_WIDTH(8)) out_if ();

    axis_frame_len_limiter #(
        .DATA_WIDTH(8), .LEN_WIDTH(16), .MAX_LEN(4), .MIN_LEN(2), .USER_BAD_FRAME_VALUE(1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .input_axis      (in_if),
        .output_axis     (out_if),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .frame_too_long  (frame_too_long),
        .frame_too_short (frame_too_short)
    );

    // Inputs change just after posedge; negedge sees settled values of the coming handshake.
    always @(negedge clk) begin
        if (out_if.tvalid && out_if.tready) obq.push_back({out_if.tdata, out_if.tlast, out_if.tuser});
        if (frame_len_valid) stq.push_back({frame_len, frame_too_long, frame_too_short});
    end

    task automatic send(input logic [7:0] d, input logic l, input logic u);
        bit ok = 1'b0;
        in_if.tdata  = d;
        in_if.tlast  = l;
        in_if.tuser  = u;
        in_if.tvalid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_if.tready;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout data=%0h: tready stayed 0, required 1", d);
        end
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
        out_if.tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL reset_in_tready got=%b required=0", in_if.tready); end
        checks++; if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_out_tvalid got=%b required=0", out_if.tvalid); end
        checks++; if ({out_if.tdata, out_if.tlast, out_if.tuser} !== 10'h0) begin errors++; $display("FAIL reset_out_payload got=%h required=0", {out_if.tdata, out_if.tlast, out_if.tuser}); end
        checks++; if ({frame_len, frame_len_valid, frame_too_long, frame_too_short} !== 19'h0) begin errors++; $display("FAIL reset_status got=%h required=0", {frame_len, frame_len_valid, frame_too_long, frame_too_short}); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_if.tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready got=%b required=1", in_if.tready); end
    endtask

    task automatic test_basic();
        logic [9:0] eb [3] = '{{8'd1, 2'b00}, {8'd2, 2'b00}, {8'd3, 2'b10}};
        obq.delete(); stq.delete();
        send(8'd1, 1'b0, 1'b0);
        checks++; if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'd1) begin errors++; $display("FAIL basic_latency got valid=%b data=%0h required valid=1 data=1", out_if.tvalid, out_if.tdata); end
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b1, 1'b0);
        drain();
        checks++; if (obq.size() != 3) begin errors++; $display("FAIL basic_count got=%0d required=3", obq.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obq.size() || obq[i] !== eb[i]) begin errors++; $display("FAIL basic_beat%0d got=%h required=%h", i, (i < obq.size()) ? obq[i] : 10'hx, eb[i]); end
        end
        checks++; if (stq.size() != 1 || stq[0] !== {16'd3, 2'b00}) begin errors++; $display("FAIL basic_status got n=%0d first=%h required n=1 %h", stq.size(), (stq.size() > 0) ? stq[0] : 18'hx, {16'd3, 2'b00}); end
    endtask

    task automatic test_short();
        obq.delete(); stq.delete();
        send(8'd9, 1'b1, 1'b0);
        drain();
        checks++; if (obq.size() != 1 || obq[0] !== {8'd9, 2'b11}) begin errors++; $display("FAIL short_beat got n=%0d first=%h required n=1 %h", obq.size(), (obq.size() > 0) ? obq[0] : 10'hx, {8'd9, 2'b11}); end
        checks++; if (stq.size() != 1 || stq[0] !== {16'd1, 2'b01}) begin errors++; $display("FAIL short_status got n=%0d first=%h required n=1 %h", stq.size(), (stq.size() > 0) ? stq[0] : 18'hx, {16'd1, 2'b01}); end
        checks++; if (frame_len !== 16'd1 || frame_too_short !== 1'b0) begin errors++; $display("FAIL short_hold got len=%0d short=%b required len=1 short=0", frame_len, frame_too_short); end
    endtask

    task automatic test_too_long();
        logic [9:0] eb [6] = '{{8'd1, 2'b00}, {8'd2, 2'b00}, {8'd3, 2'b00}, {8'd4, 2'b11}, {8'd7, 2'b00}, {8'd8, 2'b10}};
        logic [17:0] es [2] = '{{16'd6, 2'b10}, {16'd2, 2'b00}};
        obq.delete(); stq.delete();
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6, 1'b0);
        send(8'd7, 1'b0, 1'b0);
        send(8'd8, 1'b1, 1'b0);
        drain();
        checks++; if (obq.size() != 6) begin errors++; $display("FAIL long_count got=%0d required=6", obq.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= obq.size() || obq[i] !== eb[i]) begin errors++; $display("FAIL long_beat%0d got=%h required=%h", i, (i < obq.size()) ? obq[i] : 10'hx, eb[i]); end
        end
        checks++; if (stq.size() != 2) begin errors++; $display("FAIL long_status_count got=%0d required=2", stq.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= stq.size() || stq[i] !== es[i]) begin errors++; $display("FAIL long_status%0d got=%h required=%h", i, (i < stq.size()) ? stq[i] : 18'hx, es[i]); end
        end
    endtask

    task automatic test_exact_max();
        logic [9:0] eb [4] = '{{8'h21, 2'b00}, {8'h22, 2'b00}, {8'h23, 2'b00}, {8'h24, 2'b10}};
        obq.delete(); stq.delete();
        for (int i = 1; i <= 4; i++) send(8'(8'h20 + i), i == 4, 1'b0);
        drain();
        checks++; if (obq.size() != 4) begin errors++; $display("FAIL exact_count got=%0d required=4", obq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obq.size() || obq[i] !== eb[i]) begin errors++; $display("FAIL exact_beat%0d got=%h required=%h", i, (i < obq.size()) ? obq[i] : 10'hx, eb[i]); end
        end
        checks++; if (stq.size() != 1 || stq[0] !== {16'd4, 2'b00}) begin errors++; $display("FAIL exact_status got n=%0d first=%h required n=1 %h", stq.size(), (stq.size() > 0) ? stq[0] : 18'hx, {16'd4, 2'b00}); end
    endtask

    task automatic test_user_flag();
        logic [9:0] eb [3] = '{{8'h31, 2'b00}, {8'h32, 2'b00}, {8'h33, 2'b11}};
        obq.delete(); stq.delete();
        send(8'h31, 1'b0, 1'b0);
        send(8'h32, 1'b0, 1'b1);
        send(8'h33, 1'b1, 1'b0);
        drain();
        checks++; if (obq.size() != 3) begin errors++; $display("FAIL user_count got=%0d required=3", obq.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obq.size() || obq[i] !== eb[i]) begin errors++; $display("FAIL user_beat%0d got=%h required=%h", i, (i < obq.size()) ? obq[i] : 10'hx, eb[i]); end
        end
        checks++; if (stq.size() != 1 || stq[0] !== {16'd3, 2'b00}) begin errors++; $display("FAIL user_status got n=%0d first=%h required n=1 %h", stq.size(), (stq.size() > 0) ? stq[0] : 18'hx, {16'd3, 2'b00}); end
    endtask

    task automatic test_backpressure();
        logic [9:0] eb [4] = '{{8'h11, 2'b00}, {8'h12, 2'b00}, {8'h13, 2'b00}, {8'h14, 2'b10}};
        obq.delete(); stq.delete();
        out_if.tready = 1'b0;
        send(8'h11, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL bp_tready_fall got=%b required=0", in_if.tready); end
        checks++; if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h11) begin errors++; $display("FAIL bp_head got valid=%b data=%h required valid=1 data=11", out_if.tvalid, out_if.tdata); end
        in_if.tdata  = 8'h13;
        in_if.tvalid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (out_if.tdata !== 8'h11 || out_if.tlast !== 1'b0 || in_if.tready !== 1'b0) begin errors++; $display("FAIL bp_hold got data=%h last=%b tready=%b required data=11 last=0 tready=0", out_if.tdata, out_if.tlast, in_if.tready); end
        end
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
        send(8'h13, 1'b0, 1'b0);
        send(8'h14, 1'b1, 1'b0);
        drain();
        checks++; if (obq.size() != 4) begin errors++; $display("FAIL bp_count got=%0d required=4", obq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obq.size() || obq[i] !== eb[i]) begin errors++; $display("FAIL bp_beat%0d got=%h required=%h", i, (i < obq.size()) ? obq[i] : 10'hx, eb[i]); end
        end
        checks++; if (stq.size() != 1 || stq[0] !== {16'd4, 2'b00}) begin errors++; $display("FAIL bp_status got n=%0d first=%h required n=1 %h", stq.size(), (stq.size() > 0) ? stq[0] : 18'hx, {16'd4, 2'b00}); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] eb [2] = '{{8'hB1, 2'b00}, {8'hB2, 2'b10}};
        obq.delete(); stq.delete();
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        obq.delete(); stq.delete();
        checks++; if (in_if.tready !== 1'b0 || out_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_outputs got tready=%b tvalid=%b required 0 0", in_if.tready, out_if.tvalid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'hB1, 1'b0, 1'b0);
        send(8'hB2, 1'b1, 1'b0);
        drain();
        checks++; if (obq.size() != 2) begin errors++; $display("FAIL midrst_count got=%0d required=2", obq.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= obq.size() || obq[i] !== eb[i]) begin errors++; $display("FAIL midrst_beat%0d got=%h required=%h", i, (i < obq.size()) ? obq[i] : 10'hx, eb[i]); end
        end
        checks++; if (stq.size() != 1 || stq[0] !== {16'd2, 2'b00}) begin errors++; $display("FAIL midrst_status got n=%0d first=%h required n=1 %h", stq.size(), (stq.size() > 0) ? stq[0] : 18'hx, {16'd2, 2'b00}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_too_long();
        test_exact_max();
        test_user_flag();
        test_backpressure();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
